// File: rtl/dp_mem_arb_pkg.sv
// Shared defaults and requester-ID encoding for the dual-port memory arbiter.
// Round-robin arbitration is enabled by defining DP_MEM_ARB_RR_EN; otherwise A has fixed priority.
package dp_mem_arb_pkg;

    localparam int DW_DEFAULT = 16;
    localparam int AW_DEFAULT = 10;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/dp_mem_arbiter_arb2_rr.sv
// Two-way arbiter for one memory port (module arb2_rr), used once for writes and once for reads.
// With DP_MEM_ARB_RR_EN a 1-bit last-winner pointer gives round-robin; without it A always wins.
module arb2_rr
    import dp_mem_arb_pkg::*;
(
`ifdef DP_MEM_ARB_RR_EN
    input  logic clk,
    input  logic reset,
`endif
    input  logic req_a,
    input  logic req_b,
    input  logic en,
    output logic gnt_a,
    output logic gnt_b,
    output logic cand_b
);

`ifdef DP_MEM_ARB_RR_EN
    logic last_win;

    // Reset points at B so A takes the first contention.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_win <= REQ_B;
        end else if (gnt_a || gnt_b) begin
            last_win <= gnt_b ? REQ_B : REQ_A;
        end
    end

    always_comb begin
        if (req_a && req_b) begin
            cand_b = (last_win == REQ_A);
        end else begin
            cand_b = req_b;
        end
    end
`else
    assign cand_b = req_b && !req_a;
`endif

    // The candidate is independent of en, so a withheld grant cannot loop back into selection.
    assign gnt_a = en && req_a && !cand_b;
    assign gnt_b = en && req_b && cand_b;

endmodule

// File: rtl/dp_mem_arbiter.sv
// Arbitrates two requesters onto a simple dual-port memory with a 1-cycle registered read.
// Define DP_MEM_ARB_RR_EN for round-robin arbitration; default build uses fixed priority to A.
module dp_mem_arbiter
    import dp_mem_arb_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wreq_a,
    input  logic          wreq_b,
    input  logic [AW-1:0] wadr_a,
    input  logic [AW-1:0] wadr_b,
    input  logic [DW-1:0] wdata_a,
    input  logic [DW-1:0] wdata_b,
    output logic          wgnt_a,
    output logic          wgnt_b,
    input  logic          rreq_a,
    input  logic          rreq_b,
    input  logic [AW-1:0] radr_a,
    input  logic [AW-1:0] radr_b,
    output logic          rgnt_a,
    output logic          rgnt_b,
    output logic          rvalid_a,
    output logic          rvalid_b,
    output logic [DW-1:0] rdata,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_wr_adr,
    output logic [DW-1:0] mem_data_in,
    output logic [AW-1:0] mem_rd_adr,
    input  logic [DW-1:0] mem_data_out
);

    logic          wr_cand_b;
    logic          rd_cand_b;
    logic [AW-1:0] rd_cand_adr;
    logic          rd_hazard;
    logic          rd_en;
    logic          rvalid_a_q;
    logic          rvalid_b_q;

    arb2_rr u_wr_arb (
`ifdef DP_MEM_ARB_RR_EN
        .clk    (clk),
        .reset  (reset),
`endif
        .req_a  (wreq_a),
        .req_b  (wreq_b),
        .en     (reset),
        .gnt_a  (wgnt_a),
        .gnt_b  (wgnt_b),
        .cand_b (wr_cand_b)
    );

    assign mem_wr_en   = wgnt_a || wgnt_b;
    assign mem_wr_adr  = wr_cand_b ? wadr_b  : wadr_a;
    assign mem_data_in = wr_cand_b ? wdata_b : wdata_a;

    // Memory reads old data on a same-address collision, so hold the read back one cycle.
    assign rd_cand_adr = rd_cand_b ? radr_b : radr_a;
    assign rd_hazard   = mem_wr_en && (rd_cand_adr == mem_wr_adr);
    assign rd_en       = reset && !rd_hazard;

    arb2_rr u_rd_arb (
`ifdef DP_MEM_ARB_RR_EN
        .clk    (clk),
        .reset  (reset),
`endif
        .req_a  (rreq_a),
        .req_b  (rreq_b),
        .en     (rd_en),
        .gnt_a  (rgnt_a),
        .gnt_b  (rgnt_b),
        .cand_b (rd_cand_b)
    );

    assign mem_rd_adr = rd_cand_adr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
        end else begin
            rvalid_a_q <= rgnt_a;
            rvalid_b_q <= rgnt_b;
        end
    end

    // Gating with reset drops a response whose grant landed just before reset asserted.
    assign rvalid_a = reset && rvalid_a_q;
    assign rvalid_b = reset && rvalid_b_q;
    assign rdata    = (rvalid_a || rvalid_b) ? mem_data_out : '0;

endmodule

// File: tb/tb_dp_mem_arbiter.sv
// Scoreboard bench for dp_mem_arbiter: a behavioural model predicts grants and read returns,
// a monitor compares them at each falling edge. Honours DP_MEM_ARB_RR_EN when defined.
module tb_dp_mem_arbiter;
    import dp_mem_arb_pkg::*;

    localparam int DW = 16;
    localparam int AW = 10;
`ifdef DP_MEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          wreq_a, wreq_b, rreq_a, rreq_b;
    logic [AW-1:0] wadr_a, wadr_b, radr_a, radr_b;
    logic [DW-1:0] wdata_a, wdata_b;
    logic          wgnt_a, wgnt_b, rgnt_a, rgnt_b, rvalid_a, rvalid_b;
    logic [DW-1:0] rdata;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_adr, mem_rd_adr;
    logic [DW-1:0] mem_data_in, mem_data_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dp_mem_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .wreq_a       (wreq_a),
        .wreq_b       (wreq_b),
        .wadr_a       (wadr_a),
        .wadr_b       (wadr_b),
        .wdata_a      (wdata_a),
        .wdata_b      (wdata_b),
        .wgnt_a       (wgnt_a),
        .wgnt_b       (wgnt_b),
        .rreq_a       (rreq_a),
        .rreq_b       (rreq_b),
        .radr_a       (radr_a),
        .radr_b       (radr_b),
        .rgnt_a       (rgnt_a),
        .rgnt_b       (rgnt_b),
        .rvalid_a     (rvalid_a),
        .rvalid_b     (rvalid_b),
        .rdata        (rdata),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_adr   (mem_wr_adr),
        .mem_data_in  (mem_data_in),
        .mem_rd_adr   (mem_rd_adr),
        .mem_data_out (mem_data_out)
    );

    // Simple dual-port memory, registered read, read-old-data on collision.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_wr_adr] <= mem_data_in;
        mem_data_out <= mem[mem_rd_adr];
    end

    typedef struct {
        bit            rst_n;
        bit            wa, wb, ra, rb;
        logic [AW-1:0] wadr;
        logic [DW-1:0] wdat;
        logic [AW-1:0] radr;
    } cyc_exp_t;

    typedef struct {
        bit            owner_b;
        logic [DW-1:0] data;
    } rd_exp_t;

    cyc_exp_t gq[$];
    rd_exp_t  rq[$];

    // Reference model state: memory contents, last winner per port, read in flight.
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    bit            last_w, last_r;
    bit            pend;
    rd_exp_t       pend_e;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Returns 1 when B should win between the two requests.
    function automatic bit pick_b(input bit a, input bit b, input bit last);
        if (a && b) return RR_EN ? (last == REQ_A) : 1'b0;
        return b;
    endfunction

    task automatic model_cycle();
        cyc_exp_t      e;
        bit            wb, rb;
        logic [AW-1:0] adr;
        e = '{default: 0};
        e.rst_n = reset;
        if (!reset) begin
            last_w = REQ_B;
            last_r = REQ_B;
            pend   = 1'b0;
        end else begin
            if (pend) begin
                rq.push_back(pend_e);
                pend = 1'b0;
            end
            if (wreq_a || wreq_b) begin
                wb     = pick_b(wreq_a, wreq_b, last_w);
                e.wa   = !wb;
                e.wb   = wb;
                e.wadr = wb ? wadr_b : wadr_a;
                e.wdat = wb ? wdata_b : wdata_a;
                last_w = wb;
            end
            if (rreq_a || rreq_b) begin
                rb  = pick_b(rreq_a, rreq_b, last_r);
                adr = rb ? radr_b : radr_a;
                if (!((e.wa || e.wb) && adr == e.wadr)) begin
                    e.ra           = !rb;
                    e.rb           = rb;
                    e.radr         = adr;
                    last_r         = rb;
                    pend           = 1'b1;
                    pend_e.owner_b = rb;
                    pend_e.data    = shadow[adr];
                end
            end
            if (e.wa || e.wb) shadow[e.wadr] = e.wdat;
        end
        gq.push_back(e);
    endtask

    task automatic step();
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wreq_a = 0; wreq_b = 0; rreq_a = 0; rreq_b = 0;
    endtask

    initial begin : monitor
        cyc_exp_t e;
        rd_exp_t  r;
        bit       has;
        forever begin
            @(negedge clk);
            if (gq.size() > 0) begin
                e = gq.pop_front();
                chk("wgnt_a", wgnt_a, e.wa);
                chk("wgnt_b", wgnt_b, e.wb);
                chk("rgnt_a", rgnt_a, e.ra);
                chk("rgnt_b", rgnt_b, e.rb);
                chk("mem_wr_en", mem_wr_en, e.wa || e.wb);
                if (e.wa || e.wb) begin
                    chk("mem_wr_adr", mem_wr_adr, e.wadr);
                    chk("mem_data_in", mem_data_in, e.wdat);
                end
                if (e.ra || e.rb) chk("mem_rd_adr", mem_rd_adr, e.radr);
                if (!e.rst_n) chk("rdata_in_reset", rdata, 0);
                has = (rq.size() > 0);
                r   = '{default: 0};
                if (has) r = rq.pop_front();
                chk("rvalid_a", rvalid_a, has && !r.owner_b);
                chk("rvalid_b", rvalid_b, has && r.owner_b);
                if (has) chk("rdata", rdata, r.data);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: stimulus did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        reset = 0;
        idle();
        wadr_a = 0; wadr_b = 0; radr_a = 0; radr_b = 0;
        wdata_a = 0; wdata_b = 0;
        last_w = REQ_B; last_r = REQ_B; pend = 0; pend_e = '{default: 0};
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]    = '0;
            shadow[i] = '0;
        end
        mem_data_out = '0;
        @(posedge clk);
        #1;
        step();
        step();
        reset = 1;

        // Contention on the write port right after reset.
        wreq_a = 1; wreq_b = 1; wadr_a = 10; wadr_b = 11;
        wdata_a = 16'h1111; wdata_b = 16'h2222;
        repeat (4) step();

        wreq_b = 0; wadr_a = 5; wdata_a = 16'hAAAA;
        step();

        wreq_a = 0; rreq_b = 1; radr_b = 5;
        step();
        rreq_b = 0;
        step();

        // Same-cycle write and read of address 7.
        wreq_a = 1; wadr_a = 7; wdata_a = 16'h7777; rreq_a = 1; radr_a = 7;
        step();
        wreq_a = 0;
        step();
        rreq_a = 0;
        step();

        // Read granted, then reset with everything requesting.
        rreq_a = 1; radr_a = 10;
        step();
        reset = 0; wreq_a = 1; wreq_b = 1; rreq_b = 1; radr_b = 3;
        step();
        reset = 1;
        step();
        idle();
        step();

        for (int n = 0; n < 1500; n++) begin
            reset   = ($urandom_range(0, 39) != 0);
            wreq_a  = $urandom_range(0, 1);
            wreq_b  = $urandom_range(0, 1);
            rreq_a  = $urandom_range(0, 1);
            rreq_b  = $urandom_range(0, 1);
            wadr_a  = AW'($urandom_range(0, 7));
            wadr_b  = AW'($urandom_range(0, 7));
            radr_a  = AW'($urandom_range(0, 7));
            radr_b  = AW'($urandom_range(0, 7));
            wdata_a = DW'($urandom);
            wdata_b = DW'($urandom);
            step();
        end

        reset = 1;
        idle();
        repeat (3) step();
        @(negedge clk);
        #1;
        chk("read_queue_drained", rq.size(), 0);
        chk("cycle_queue_drained", gq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
